// File: rtl/squeeze_conv_engine.sv
// squeeze_conv_engine
//
// Pointwise / KxK convolution engine for the fire-module squeeze stages.
// DSP_NO signed MACs share one IFM word per cycle and each takes its own
// kernel word. After N = KERNEL_DIM*KERNEL_DIM*CHIN taps, every MAC holds
// one output-channel value. That value gets a bias add, an arithmetic right
// shift, and a saturating clamp (ReLU or signed) before it lands in ofm.
//
// Ports
//   clk             : clock
//   rst             : synchronous, active-high reset
//   layer_en        : tap-advance enable; low stalls the tap/pixel/acc state
//   ifm_i           : IFM word for the current tap
//   kernels         : DSP_NO kernel words for the current tap
//   bias            : DSP_NO per-channel biases (product scale, 2*WIDTH bits)
//   ram_feedback    : writer has consumed the layer (only honoured in DONE)
//   rom_clr_pulse_o : this cycle accepts the last tap of a pixel
//   layer_sample    : one-cycle strobe, ofm holds a new pixel
//   layer_finish    : all pixels emitted, waiting for ram_feedback
//   ofm             : requantised output pixel, one word per channel

module squeeze_conv_engine #(
    parameter int DSP_NO     = 112,
    parameter int WIDTH      = 16,
    parameter int CHIN       = 512,
    parameter int KERNEL_DIM = 1,
    parameter int WOUT       = 8,
    parameter int FRAC_SHIFT = 14,
    parameter int RELU       = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             layer_en,
    input  logic [WIDTH-1:0]                 ifm_i,
    input  logic [DSP_NO-1:0][WIDTH-1:0]     kernels,
    input  logic [DSP_NO-1:0][2*WIDTH-1:0]   bias,
    input  logic                             ram_feedback,
    output logic                             rom_clr_pulse_o,
    output logic                             layer_sample,
    output logic                             layer_finish,
    output logic [DSP_NO-1:0][WIDTH-1:0]     ofm
);

    localparam int N     = KERNEL_DIM * KERNEL_DIM * CHIN;
    localparam int P     = WOUT * WOUT;
    localparam int ACC_W = 2 * WIDTH + $clog2(N) + 1;
    localparam int EXT_W = ACC_W - 2 * WIDTH;
    localparam int TAP_W = (N > 1) ? $clog2(N) : 1;
    localparam int PIX_W = (P > 1) ? $clog2(P) : 1;

    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(N - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(P - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic signed [ACC_W-1:0] Q_MAX  = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Q_MIN  = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] Q_ZERO = '0;

    localparam logic [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]        state;
    logic [TAP_W-1:0]  tap;
    logic [PIX_W-1:0]  pix;
    logic              out_pending;
    logic              accept;
    logic              last_tap;
    logic              last_pix;

    logic signed [ACC_W-1:0]   acc      [DSP_NO];
    logic signed [2*WIDTH-1:0] ifm_ext;
    logic signed [2*WIDTH-1:0] k_ext    [DSP_NO];
    logic signed [2*WIDTH-1:0] prod     [DSP_NO];
    logic signed [ACC_W-1:0]   acc_next [DSP_NO];
    logic signed [ACC_W-1:0]   sum_full [DSP_NO];
    logic signed [ACC_W-1:0]   shifted  [DSP_NO];
    logic [WIDTH-1:0]          quant    [DSP_NO];

    // Taps are taken in IDLE as well as RUN, because the cycle that leaves
    // IDLE is already tap 0 of pixel 0. In IDLE the tap counter is always
    // zero, so the only effect on the pulse is for single-tap kernels. There,
    // the first cycle of a run is also a last tap and is flagged as such.
    always_comb begin
        accept          = layer_en && ((state == S_IDLE) || (state == S_RUN));
        last_tap        = accept && (tap == TAP_LAST);
        last_pix        = (pix == PIX_LAST);
        rom_clr_pulse_o = last_tap;
    end

    // MAC datapath. Tap 0 discards the previous pixel's sum instead of
    // adding to it, so back-to-back pixels need no separate clear cycle.
    // The output stage below reads acc from the register, so it still sees
    // the finished sum in the cycle where the next pixel's tap 0 overwrites it.
    always_comb begin
        ifm_ext = {{WIDTH{ifm_i[WIDTH-1]}}, ifm_i};
        for (int i = 0; i < DSP_NO; i++) begin
            k_ext[i]    = {{WIDTH{kernels[i][WIDTH-1]}}, kernels[i]};
            prod[i]     = ifm_ext * k_ext[i];
            acc_next[i] = ((tap == '0) ? Q_ZERO : acc[i])
                          + {{EXT_W{prod[i][2*WIDTH-1]}}, prod[i]};
        end
    end

    // Requantisation. The accumulator is wide enough that adding the bias
    // cannot wrap. The shift floors toward minus infinity, and the clamp
    // saturates to the output word instead of dropping high bits.
    always_comb begin
        for (int i = 0; i < DSP_NO; i++) begin
            sum_full[i] = acc[i] + {{EXT_W{bias[i][2*WIDTH-1]}}, bias[i]};
            shifted[i]  = sum_full[i] >>> FRAC_SHIFT;
            if (shifted[i] > Q_MAX) begin
                quant[i] = OUT_MAX;
            end else if (shifted[i] < Q_ZERO) begin
                if (RELU != 0) begin
                    quant[i] = '0;
                end else if (shifted[i] < Q_MIN) begin
                    quant[i] = OUT_MIN;
                end else begin
                    quant[i] = shifted[i][WIDTH-1:0];
                end
            end else begin
                quant[i] = shifted[i][WIDTH-1:0];
            end
        end
    end

    // Control, accumulators and output registers.
    // out_pending marks the cycle in which acc holds a finished pixel. The
    // output stage registers ofm and raises layer_sample at the end of that
    // cycle, which gives a two-cycle latency from the last tap to the sample.
    // DRAIN waits for the final sample. It is the only sample seen in DRAIN
    // while no other pixel is pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            tap          <= '0;
            pix          <= '0;
            out_pending  <= 1'b0;
            layer_sample <= 1'b0;
            layer_finish <= 1'b0;
            ofm          <= '0;
            for (int i = 0; i < DSP_NO; i++) begin
                acc[i] <= '0;
            end
        end else begin
            layer_sample <= out_pending;
            out_pending  <= last_tap;

            if (out_pending) begin
                for (int i = 0; i < DSP_NO; i++) begin
                    ofm[i] <= quant[i];
                end
            end

            if (accept) begin
                for (int i = 0; i < DSP_NO; i++) begin
                    acc[i] <= acc_next[i];
                end
                tap <= last_tap ? '0 : tap + TAP_W'(1);
                if (last_tap) begin
                    pix <= last_pix ? '0 : pix + PIX_W'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (layer_en) begin
                        state <= (last_tap && last_pix) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (last_tap && last_pix) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (layer_sample && !out_pending) begin
                        state        <= S_DONE;
                        layer_finish <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (ram_feedback) begin
                        state        <= S_IDLE;
                        layer_finish <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_squeeze_conv_engine.sv
// tb_squeeze_conv_engine
//
// Drives two copies of the engine side by side, one with RELU=1 and one with
// RELU=0, from the same inputs. A reference model works out each pixel's
// output with plain integer arithmetic and queues it with the cycle in which
// layer_sample should show it. A negedge monitor checks each sample against
// that queue.
//
// Ports: none (top-level bench).

`timescale 1ns/1ps

module tb_squeeze_conv_engine;

    localparam int DSP_NO     = 2;
    localparam int WIDTH      = 16;
    localparam int CHIN       = 4;
    localparam int KERNEL_DIM = 1;
    localparam int WOUT       = 2;
    localparam int FRAC_SHIFT = 14;
    localparam int NT         = KERNEL_DIM * KERNEL_DIM * CHIN;
    localparam int NP         = WOUT * WOUT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic layer_en = 1'b0;
    logic ram_feedback = 1'b0;
    logic [WIDTH-1:0]               ifm_i = '0;
    logic [DSP_NO-1:0][WIDTH-1:0]   kernels = '0;
    logic [DSP_NO-1:0][2*WIDTH-1:0] bias = '0;

    logic rom_r, samp_r, fin_r;
    logic rom_c, samp_c, fin_c;
    logic [DSP_NO-1:0][WIDTH-1:0] ofm_r, ofm_c;

    squeeze_conv_engine #(
        .DSP_NO(DSP_NO), .WIDTH(WIDTH), .CHIN(CHIN), .KERNEL_DIM(KERNEL_DIM),
        .WOUT(WOUT), .FRAC_SHIFT(FRAC_SHIFT), .RELU(1)
    ) dut_r (
        .clk(clk), .rst(rst), .layer_en(layer_en), .ifm_i(ifm_i),
        .kernels(kernels), .bias(bias), .ram_feedback(ram_feedback),
        .rom_clr_pulse_o(rom_r), .layer_sample(samp_r),
        .layer_finish(fin_r), .ofm(ofm_r)
    );

    squeeze_conv_engine #(
        .DSP_NO(DSP_NO), .WIDTH(WIDTH), .CHIN(CHIN), .KERNEL_DIM(KERNEL_DIM),
        .WOUT(WOUT), .FRAC_SHIFT(FRAC_SHIFT), .RELU(0)
    ) dut_c (
        .clk(clk), .rst(rst), .layer_en(layer_en), .ifm_i(ifm_i),
        .kernels(kernels), .bias(bias), .ram_feedback(ram_feedback),
        .rom_clr_pulse_o(rom_c), .layer_sample(samp_c),
        .layer_finish(fin_c), .ofm(ofm_c)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] r0;
        logic [15:0] r1;
        logic [15:0] c0;
        logic [15:0] c1;
        int          cy;
    } exp_t;

    exp_t expq[$];

    logic [15:0] ifm_tab [NP*NT];
    logic [15:0] k0_tab  [NP*NT];
    logic [15:0] k1_tab  [NP*NT];
    logic [31:0] b0_val, b1_val;

    longint macc [2];

    bit   mon_en = 1'b0;
    bit   prev_samp = 1'b0;
    int   n_samp = 0;
    int   n_rom = 0;
    int   run_start = 0;
    int   last_sample_cyc = 0;
    logic [31:0] got_r [8];
    logic [31:0] got_c [8];
    int          got_rel [8];
    logic [31:0] save_r [NP];
    logic [31:0] save_c [NP];
    int          save_rel [NP];

    // Every comparison goes through here. It counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h want=0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference requantisation: floor division by 2^FRAC_SHIFT, then clamp
    // to the 16-bit output range.
    function automatic logic [15:0] quantRef(input longint s, input bit relu);
        longint d;
        longint q;
        d = longint'(1) << FRAC_SHIFT;
        q = s / d;
        if ((s % d != 0) && (s < 0)) q = q - 1;
        if (q > 32767) return 16'h7FFF;
        if (q < 0 && relu) return 16'h0000;
        if (q < -32768) return 16'h8000;
        return 16'(q);
    endfunction

    // Fill the per-tap tables for one layer.
    // mode 0 = random, 1 = basic, 2 = sign, 3 = positive saturation,
    // 4 = negative saturation.
    task automatic fillTables(input int mode);
        logic [31:0] r;
        for (int i = 0; i < NP*NT; i++) begin
            case (mode)
                1: begin ifm_tab[i] = 16'h4000; k0_tab[i] = 16'h1000; k1_tab[i] = 16'h1000; end
                2: begin ifm_tab[i] = 16'h4000; k0_tab[i] = 16'h1000; k1_tab[i] = 16'hF000; end
                3: begin ifm_tab[i] = 16'h7FFF; k0_tab[i] = 16'h7FFF; k1_tab[i] = 16'h7FFF; end
                4: begin ifm_tab[i] = 16'h7FFF; k0_tab[i] = 16'h8001; k1_tab[i] = 16'h8001; end
                default: begin
                    r = $urandom;
                    ifm_tab[i] = {{2{r[13]}}, r[13:0]};
                    r = $urandom;
                    k0_tab[i] = {{2{r[13]}}, r[13:0]};
                    r = $urandom;
                    k1_tab[i] = (i % 5 == 0) ? r[31:16] : {{2{r[13]}}, r[13:0]};
                end
            endcase
        end
        case (mode)
            1, 2: begin b0_val = 32'h0; b1_val = 32'h0; end
            3, 4: begin b0_val = 32'h7FFFFFFF; b1_val = 32'h7FFFFFFF; end
            default: begin
                r = $urandom;
                b0_val = {{8{r[23]}}, r[23:0]};
                r = $urandom;
                b1_val = {{8{r[23]}}, r[23:0]};
            end
        endcase
    endtask

    // Present one accepted tap. On the last tap of a pixel the model queues
    // the expected output and the cycle in which it should appear.
    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] k0,
                                 input logic [15:0] k1, input bit first, input bit last);
        exp_t e;
        ifm_i = x;
        kernels[0] = k0;
        kernels[1] = k1;
        layer_en = 1'b1;
        if (first) begin
            macc[0] = 0;
            macc[1] = 0;
        end
        macc[0] += longint'($signed(x)) * longint'($signed(k0));
        macc[1] += longint'($signed(x)) * longint'($signed(k1));
        if (last) begin
            e.r0 = quantRef(macc[0] + longint'($signed(b0_val)), 1'b1);
            e.r1 = quantRef(macc[1] + longint'($signed(b1_val)), 1'b1);
            e.c0 = quantRef(macc[0] + longint'($signed(b0_val)), 1'b0);
            e.c1 = quantRef(macc[1] + longint'($signed(b1_val)), 1'b0);
            e.cy = cyc + 2;
            expq.push_back(e);
        end
        @(negedge clk);
        checkOutput("rom_clr_relu", rom_r, last);
        checkOutput("rom_clr_clamp", rom_c, last);
        @(posedge clk);
        #1;
    endtask

    // One stalled cycle: random data on the buses and layer_en low.
    task automatic stallCycle();
        layer_en = 1'b0;
        ifm_i = 16'($urandom);
        kernels = 32'($urandom);
        @(negedge clk);
        checkOutput("rom_clr_stall", rom_r, 0);
        @(posedge clk);
        #1;
    endtask

    // Run one full layer from the current tables and optionally stall before
    // tap 2 of stall_pix. Then check the finish flag and complete the RAM
    // handshake.
    task automatic runLayer(input int stall_pix, input int stall_len);
        bit fin_seen;
        int fin_cyc;
        bias[0] = b0_val;
        bias[1] = b1_val;
        n_samp = 0;
        n_rom = 0;
        run_start = cyc;
        for (int p = 0; p < NP; p++) begin
            for (int t = 0; t < NT; t++) begin
                if (p == stall_pix && t == 2) begin
                    for (int s = 0; s < stall_len; s++) stallCycle();
                end
                applyStimulus(ifm_tab[p*NT+t], k0_tab[p*NT+t], k1_tab[p*NT+t], t == 0, t == NT-1);
            end
        end
        layer_en = 1'b0;
        fin_seen = 1'b0;
        fin_cyc = 0;
        for (int w = 0; w < 20 && !fin_seen; w++) begin
            @(negedge clk);
            if (fin_r) begin
                fin_seen = 1'b1;
                fin_cyc = cyc;
            end
        end
        checkOutput("finish_seen", fin_seen, 1);
        checkOutput("finish_after_last_sample", fin_cyc, last_sample_cyc + 1);
        checkOutput("finish_clamp", fin_c, 1);
        checkOutput("sample_count", n_samp, NP);
        checkOutput("rom_clr_count", n_rom, NP);
        checkOutput("pending_expected", expq.size(), 0);
        @(posedge clk);
        #1;
        ram_feedback = 1'b1;
        @(negedge clk);
        checkOutput("finish_held", fin_r, 1);
        @(posedge clk);
        #1;
        ram_feedback = 1'b0;
        @(negedge clk);
        checkOutput("finish_drop_relu", fin_r, 0);
        checkOutput("finish_drop_clamp", fin_c, 0);
        @(posedge clk);
        #1;
    endtask

    // Sample monitor: each layer_sample must match the next queued pixel,
    // both for its data and for the cycle in which it appears.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (samp_r) begin
                checkOutput("sample_pair", samp_c, 1);
                checkOutput("sample_back_to_back", prev_samp, 0);
                if (expq.size() == 0) begin
                    checkOutput("unexpected_sample", samp_r, 0);
                end else begin
                    e = expq.pop_front();
                    checkOutput("ofm_relu_ch0", ofm_r[0], e.r0);
                    checkOutput("ofm_relu_ch1", ofm_r[1], e.r1);
                    checkOutput("ofm_clamp_ch0", ofm_c[0], e.c0);
                    checkOutput("ofm_clamp_ch1", ofm_c[1], e.c1);
                    checkOutput("sample_cycle", cyc, e.cy);
                end
                if (n_samp < 8) begin
                    got_r[n_samp] = ofm_r;
                    got_c[n_samp] = ofm_c;
                    got_rel[n_samp] = cyc - run_start;
                end
                n_samp++;
                last_sample_cyc = cyc;
            end
            if (rom_r) n_rom++;
        end
        prev_samp = samp_r;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            layer_en = 1'($urandom);
            ram_feedback = 1'($urandom);
            ifm_i = 16'($urandom);
            kernels = 32'($urandom);
            bias = {32'($urandom), 32'($urandom)};
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("reset_ofm_relu", ofm_r, 0);
        checkOutput("reset_ofm_clamp", ofm_c, 0);
        checkOutput("reset_sample", samp_r, 0);
        checkOutput("reset_finish", fin_r, 0);
        checkOutput("reset_rom_clr", rom_r, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        layer_en = 1'b0;
        ram_feedback = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Basic pixel.
        fillTables(1);
        runLayer(-1, 0);
        checkOutput("basic_relu", got_r[0], 32'h40004000);
        checkOutput("basic_clamp", got_c[0], 32'h40004000);

        // Sign handling. Channel 1 sits in the upper half of the packed word.
        fillTables(2);
        runLayer(-1, 0);
        checkOutput("sign_relu", got_r[0], 32'h00004000);
        checkOutput("sign_clamp", got_c[0], 32'hC0004000);

        // Saturation, positive then negative.
        fillTables(3);
        runLayer(-1, 0);
        checkOutput("sat_pos_relu", got_r[0], 32'h7FFF7FFF);
        checkOutput("sat_pos_clamp", got_c[0], 32'h7FFF7FFF);
        fillTables(4);
        runLayer(-1, 0);
        checkOutput("sat_neg_clamp", got_c[0], 32'h80008000);
        checkOutput("sat_neg_relu", got_r[0], 32'h00000000);

        // Stall: one unstalled reference run, then the same data stalled.
        fillTables(0);
        runLayer(-1, 0);
        for (int p = 0; p < NP; p++) begin
            save_r[p] = got_r[p];
            save_c[p] = got_c[p];
            save_rel[p] = got_rel[p];
        end
        runLayer(1, 3);
        for (int p = 0; p < NP; p++) begin
            checkOutput("stall_same_relu", got_r[p], save_r[p]);
            checkOutput("stall_same_clamp", got_c[p], save_c[p]);
            checkOutput("stall_sample_delay", got_rel[p], save_rel[p] + ((p >= 1) ? 3 : 0));
        end

        // Restart: rerun the same layer and expect identical output.
        runLayer(-1, 0);
        for (int p = 0; p < NP; p++) begin
            checkOutput("rerun_same_relu", got_r[p], save_r[p]);
            checkOutput("rerun_same_clamp", got_c[p], save_c[p]);
        end

        // Mid-run reset during tap 1 of pixel 1.
        fillTables(0);
        bias[0] = b0_val;
        bias[1] = b1_val;
        n_samp = 0;
        run_start = cyc;
        for (int t = 0; t < NT; t++) begin
            applyStimulus(ifm_tab[t], k0_tab[t], k1_tab[t], t == 0, t == NT-1);
        end
        applyStimulus(ifm_tab[NT], k0_tab[NT], k1_tab[NT], 1'b1, 1'b0);
        rst = 1'b1;
        layer_en = 1'b1;
        ifm_i = ifm_tab[NT+1];
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("midrst_ofm_relu", ofm_r, 0);
        checkOutput("midrst_ofm_clamp", ofm_c, 0);
        checkOutput("midrst_sample", samp_r, 0);
        checkOutput("midrst_finish", fin_r, 0);
        checkOutput("midrst_first_pixel_seen", n_samp, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        layer_en = 1'b0;
        checkOutput("midrst_queue", expq.size(), 0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("midrst_no_partial_sample", n_samp, 1);

        // Randomised layers after the reset.
        for (int r = 0; r < 3; r++) begin
            fillTables(0);
            runLayer((r == 1) ? 2 : -1, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
